// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issue path: select codes, MIPS opcode/funct
// encodings and the issue-controller state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and result channels between the issue stage and the ALU issue controller.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [5:0]       cmd_opcode;
  logic [5:0]       cmd_funct;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_illegal;

  modport master (
    output cmd_valid, cmd_opcode, cmd_funct, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_illegal
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_funct, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_illegal
  );

endinterface

// File: rtl/alu_op_decoder.sv
// Maps a MIPS opcode/funct pair onto the ALU select code; flags anything unsupported.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_sel,
  output logic       illegal
);

  always_comb begin
    alu_sel = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: alu_sel = ALU_ADD;
      OP_ANDI: alu_sel = ALU_AND;
      OP_ORI:  alu_sel = ALU_OR;
      OP_SLTI: alu_sel = ALU_SLT;
      // beq compares by subtraction, so the ALU zero flag is the taken indication
      OP_BEQ:  alu_sel = ALU_SUB;
      OP_LW:   alu_sel = ALU_ADD;
      OP_SW:   alu_sel = ALU_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded command at a time to an external combinational ALU and holds
// the captured result until the consumer takes it.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_ctrl_if.slave      bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_sel,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] dec_sel;
  logic       dec_illegal;

  alu_op_decoder u_dec (
    .opcode  (bus.cmd_opcode),
    .funct   (bus.cmd_funct),
    .alu_sel (dec_sel),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = dec_illegal ? HOLD : EXEC;
      end
      EXEC: state_d = HOLD;
      HOLD: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Illegal commands skip the ALU entirely and leave its operands untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a           <= '0;
      alu_b           <= '0;
      alu_sel         <= ALU_ADD;
      bus.res_data    <= '0;
      bus.res_zero    <= 1'b0;
      bus.res_illegal <= 1'b0;
      err_count       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (dec_illegal) begin
              bus.res_data    <= '0;
              bus.res_zero    <= 1'b0;
              bus.res_illegal <= 1'b1;
              if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
            end else begin
              alu_a   <= bus.cmd_a;
              alu_b   <= bus.cmd_b;
              alu_sel <= dec_sel;
            end
          end
        end
        EXEC: begin
          bus.res_data    <= alu_result;
          bus.res_zero    <= alu_zero;
          bus.res_illegal <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
